// File: rtl/vram_rect_writer.sv
// vram_rect_writer
//   Write-side engine for the dual-clock VRAM. Fills an axis-aligned rectangle
//   with a single RGB332 colour into a FB_W x FB_H byte-per-pixel framebuffer
//   located at BASE_ADDR, driving VRAM port B one pixel per cycle. Rectangles
//   are clipped to the framebuffer; address arithmetic wraps modulo
//   2^(ADDR_W+1).
//
// Ports
//   CLK, RST_N          system clock (rising edge), async active-low reset
//   BASE_ADDR           framebuffer byte base, captured on command accept
//   CMD_VALID/READY     command handshake; READY only while idle
//   CMD_X0/Y0/W/H       rectangle origin and size (W or H of 0 = empty)
//   CMD_COLOR           fill byte
//   ABORT               cancel the active command (setup or fill)
//   VRAM_ADDR/DATA/WE   port-B write interface, one byte per WE cycle
//   BUSY                command in setup or fill
//   DONE                one-cycle pulse on completion or abort
module vram_rect_writer #(
  parameter int ADDR_W = 17,
  parameter int FB_W   = 320,
  parameter int FB_H   = 240
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [8:0]        CMD_X0,
  input  logic [7:0]        CMD_Y0,
  input  logic [8:0]        CMD_W,
  input  logic [7:0]        CMD_H,
  input  logic [7:0]        CMD_COLOR,
  input  logic              ABORT,
  output logic [ADDR_W:0]   VRAM_ADDR,
  output logic [7:0]        VRAM_DATA,
  output logic              VRAM_WE,
  output logic              BUSY,
  output logic              DONE
);

  localparam int AW = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [9:0]    FB_W10 = 10'(FB_W);
  localparam logic [9:0]    FB_H10 = 10'(FB_H);
  localparam logic [AW-1:0] FB_WA  = AW'(FB_W);

  logic [1:0]        state;

  // Command fields captured on accept
  logic [ADDR_W-1:0] base_q;
  logic [8:0]        x0_q;
  logic [8:0]        w_q;
  logic [7:0]        y0_q;
  logic [7:0]        h_q;
  logic [7:0]        color_q;

  // Fill walk state
  logic [9:0]        x_end;
  logic [9:0]        y_end;
  logic [8:0]        x;
  logic [7:0]        y;
  logic [AW-1:0]     row_base;

  // Last written address/data, presented while not writing
  logic [AW-1:0]     addr_q;
  logic [7:0]        data_q;

  logic [9:0]        x_sum;
  logic [9:0]        y_sum;
  logic [9:0]        x_end_n;
  logic [9:0]        y_end_n;
  logic              empty;
  logic [AW-1:0]     row_base_n;
  logic              x_last;
  logic              y_last;
  logic              writing;
  logic [AW-1:0]     pix_addr;

  always_comb begin
    x_sum      = {1'b0, x0_q} + {1'b0, w_q};
    y_sum      = {2'b00, y0_q} + {2'b00, h_q};
    x_end_n    = (x_sum > FB_W10) ? FB_W10 : x_sum;
    y_end_n    = (y_sum > FB_H10) ? FB_H10 : y_sum;
    empty      = (w_q == 9'd0) || (h_q == 8'd0) ||
                 ({1'b0, x0_q} >= FB_W10) || ({2'b00, y0_q} >= FB_H10);
    row_base_n = AW'(base_q) + AW'(y0_q) * FB_WA;
    x_last     = ({1'b0, x} + 10'd1) == x_end;
    y_last     = ({2'b00, y} + 10'd1) == y_end;
    pix_addr   = row_base + AW'(x);
    // WE is combinational so that ABORT and an async reset take effect in
    // the same cycle they are seen.
    writing    = (state == S_FILL) && !ABORT;
  end

  assign VRAM_WE   = writing;
  assign VRAM_ADDR = writing ? pix_addr : addr_q;
  assign VRAM_DATA = writing ? color_q  : data_q;
  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state == S_SETUP) || (state == S_FILL);
  assign DONE      = (state == S_FIN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      base_q   <= '0;
      x0_q     <= '0;
      w_q      <= '0;
      y0_q     <= '0;
      h_q      <= '0;
      color_q  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CMD_VALID) begin
            base_q  <= BASE_ADDR;
            x0_q    <= CMD_X0;
            w_q     <= CMD_W;
            y0_q    <= CMD_Y0;
            h_q     <= CMD_H;
            color_q <= CMD_COLOR;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          x_end    <= x_end_n;
          y_end    <= y_end_n;
          row_base <= row_base_n;
          x        <= x0_q;
          y        <= y0_q;
          state    <= (ABORT || empty) ? S_FIN : S_FILL;
        end
        S_FILL: begin
          if (ABORT) begin
            state <= S_FIN;
          end else begin
            addr_q <= pix_addr;
            data_q <= color_q;
            if (x_last) begin
              if (y_last) begin
                state <= S_FIN;
              end else begin
                x        <= x0_q;
                y        <= y + 8'd1;
                row_base <= row_base + FB_WA;
              end
            end else begin
              x <= x + 9'd1;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_rect_writer.sv
// tb_vram_rect_writer
//   Directed and scoreboarded checks of vram_rect_writer: reset values,
//   plain fills, clipping, empty commands, abort, back-to-back handshake,
//   reset mid-fill, and random rectangles against a bench-side model.
module tb_vram_rect_writer;

  logic        CLK;
  logic        RST_N;
  logic [16:0] BASE_ADDR;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [8:0]  CMD_X0;
  logic [7:0]  CMD_Y0;
  logic [8:0]  CMD_W;
  logic [7:0]  CMD_H;
  logic [7:0]  CMD_COLOR;
  logic        ABORT;
  logic [17:0] VRAM_ADDR;
  logic [7:0]  VRAM_DATA;
  logic        VRAM_WE;
  logic        BUSY;
  logic        DONE;

  vram_rect_writer #(.ADDR_W(17), .FB_W(320), .FB_H(240)) dut (
    .CLK(CLK), .RST_N(RST_N), .BASE_ADDR(BASE_ADDR),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_X0(CMD_X0), .CMD_Y0(CMD_Y0), .CMD_W(CMD_W), .CMD_H(CMD_H),
    .CMD_COLOR(CMD_COLOR), .ABORT(ABORT),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA), .VRAM_WE(VRAM_WE),
    .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [17:0] got_addr[$];
  logic [7:0]  got_data[$];
  int          got_cyc[$];
  int          done_cyc;
  logic        ready_at_done;
  logic        ready_after;
  int          viol;
  logic [17:0] abort_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Offers one command and records every port-B write with its cycle index
  // relative to the accept cycle (cycle 0). abort_at/rst_at name a cycle to
  // raise ABORT or pull RST_N low (0 = never).
  task automatic run_cmd(input logic [16:0] base, input logic [8:0] x0, input logic [7:0] y0,
                         input logic [8:0] w, input logic [7:0] h, input logic [7:0] col,
                         input int abort_at, input int rst_at, input bit hold);
    int n;
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cyc      = -1;
    viol          = 0;
    ready_at_done = 1'bx;
    ready_after   = 1'bx;
    abort_addr    = '0;
    @(posedge CLK); #1;
    BASE_ADDR = base; CMD_X0 = x0; CMD_Y0 = y0; CMD_W = w; CMD_H = h;
    CMD_COLOR = col; CMD_VALID = 1'b1; ABORT = 1'b0;
    n = 0;
    while (!CMD_READY && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!CMD_READY) begin
      check("accept_timeout", 0, 1);
      CMD_VALID = 1'b0;
      return;
    end
    for (int c = 1; c <= 2000; c++) begin
      @(posedge CLK); #1;
      if (!hold) CMD_VALID = 1'b0;
      ABORT = (c == abort_at);
      if (c == rst_at) begin
        RST_N = 1'b0;
        #1;
        check("rst_we", VRAM_WE, 0);
        check("rst_ready", CMD_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_addr", VRAM_ADDR, 0);
        repeat (2) begin
          @(negedge CLK);
          check("rst_hold_done", DONE, 0);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_after_done", DONE, 0);
        check("rst_after_ready", CMD_READY, 1);
        return;
      end
      @(negedge CLK);
      if (VRAM_WE) begin
        got_addr.push_back(VRAM_ADDR);
        got_data.push_back(VRAM_DATA);
        got_cyc.push_back(c);
      end
      if (VRAM_WE && !BUSY) viol++;
      if (BUSY && CMD_READY) viol++;
      if (c == abort_at) abort_addr = VRAM_ADDR;
      if (DONE) begin
        done_cyc      = c;
        ready_at_done = CMD_READY;
        break;
      end
    end
    ABORT = 1'b0;
    if (done_cyc < 0) begin
      check("done_timeout", 0, 1);
      return;
    end
    @(posedge CLK); #1;
    if (!hold) CMD_VALID = 1'b0;
    @(negedge CLK);
    ready_after = CMD_READY;
    check("done_one_cycle", DONE, 0);
  endtask

  initial begin
    int e1[4];
    int n2;
    int bad;
    int xe, ye, nexp;
    logic [16:0] rb;
    logic [8:0]  rx0, rw;
    logic [7:0]  ry0, rh, rc;
    logic [17:0] ea;
    logic [17:0] exp_addr[$];

    RST_N = 1'b1; CMD_VALID = 1'b0; ABORT = 1'b0; BASE_ADDR = '0;
    CMD_X0 = '0; CMD_Y0 = '0; CMD_W = '0; CMD_H = '0; CMD_COLOR = '0;
    #2 RST_N = 1'b0;
    #1;
    check("reset_ready", CMD_READY, 1);
    check("reset_we", VRAM_WE, 0);
    check("reset_addr", VRAM_ADDR, 0);
    check("reset_data", VRAM_DATA, 0);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // 2x2 at origin
    e1 = '{0, 1, 320, 321};
    run_cmd(17'h0, 9'd0, 8'd0, 9'd2, 8'd2, 8'hE0, 0, 0, 1'b0);
    check("t1_count", got_addr.size(), 4);
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      check("t1_addr", got_addr[i], e1[i]);
      check("t1_data", got_data[i], 8'hE0);
      check("t1_cyc", got_cyc[i], i + 2);
    end
    check("t1_done", done_cyc, 6);
    check("t1_ready_after", ready_after, 1);

    // Bottom-right corner, clipped to 2x1
    run_cmd(17'h4000, 9'd318, 8'd239, 9'd5, 8'd4, 8'h1C, 0, 0, 1'b0);
    check("t2_count", got_addr.size(), 2);
    if (got_addr.size() >= 2) begin
      check("t2_addr0", got_addr[0], 93182);
      check("t2_addr1", got_addr[1], 93183);
    end
    check("t2_done", done_cyc, 4);

    // Empty commands
    run_cmd(17'h0, 9'd5, 8'd5, 9'd0, 8'd3, 8'hFF, 0, 0, 1'b0);
    check("t3a_count", got_addr.size(), 0);
    check("t3a_done", done_cyc, 2);
    check("t3a_ready_c3", ready_after, 1);
    run_cmd(17'h0, 9'd320, 8'd5, 9'd5, 8'd5, 8'hFF, 0, 0, 1'b0);
    check("t3b_count", got_addr.size(), 0);
    check("t3b_done", done_cyc, 2);
    run_cmd(17'h0, 9'd5, 8'd240, 9'd5, 8'd5, 8'hFF, 0, 0, 1'b0);
    check("t3c_count", got_addr.size(), 0);

    // Abort on the 4th write cycle (cycle 5)
    run_cmd(17'h100, 9'd5, 8'd3, 9'd10, 8'd10, 8'h55, 5, 0, 1'b0);
    check("t4_count", got_addr.size(), 3);
    check("t4_done", done_cyc, 6);
    check("t4_addr_hold", abort_addr, 1223);
    check("t4_ready_after", ready_after, 1);

    // CMD_VALID held across back-to-back commands
    run_cmd(17'h0, 9'd10, 8'd1, 9'd3, 8'd1, 8'h03, 0, 0, 1'b1);
    check("t5_count", got_addr.size(), 3);
    check("t5_done", done_cyc, 5);
    check("t5_ready_in_fin", ready_at_done, 0);
    check("t5_ready_after", ready_after, 1);
    check("t5_viol", viol, 0);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    @(negedge CLK);
    check("t5_second_busy", BUSY, 1);
    check("t5_second_ready", CMD_READY, 0);
    n2 = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (VRAM_WE) n2++;
      if (DONE) break;
    end
    check("t5_second_done", DONE, 1);
    check("t5_second_count", n2, 3);

    // Reset in the middle of a fill (writes on cycles 2..5, reset in 6)
    run_cmd(17'h0, 9'd0, 8'd0, 9'd10, 8'd10, 8'hAA, 0, 6, 1'b0);
    check("t6_count", got_addr.size(), 4);
    check("t6_no_done", done_cyc, -1);

    // Random rectangles against the bench model
    for (int r = 0; r < 100; r++) begin
      rb  = (r % 4 == 0) ? 17'(17'h1FFFF - $urandom_range(0, 255)) : 17'($urandom);
      rx0 = 9'($urandom_range(0, 330));
      ry0 = 8'($urandom_range(0, 245));
      rw  = 9'($urandom_range(0, 24));
      rh  = 8'($urandom_range(0, 16));
      rc  = 8'($urandom);
      xe = int'(rx0) + int'(rw); if (xe > 320) xe = 320;
      ye = int'(ry0) + int'(rh); if (ye > 240) ye = 240;
      exp_addr.delete();
      for (int yy = int'(ry0); yy < ye; yy++)
        for (int xx = int'(rx0); xx < xe; xx++) begin
          ea = 18'(int'(rb) + yy * 320 + xx);
          exp_addr.push_back(ea);
        end
      nexp = exp_addr.size();
      run_cmd(rb, rx0, ry0, rw, rh, rc, 0, 0, 1'b0);
      check("sb_count", got_addr.size(), nexp);
      bad = 0;
      for (int i = 0; i < nexp && i < got_addr.size(); i++)
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== rc || got_cyc[i] != i + 2) bad++;
      check("sb_pixels", bad, 0);
      check("sb_done", done_cyc, nexp + 2);
      check("sb_viol", viol, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
